// File: rtl/jtkiwi_draw_pkg.sv
// Shared definitions for the SETA tile row renderer: FSM encoding, field
// positions in the draw command and the plane de-interleave helper.
package jtkiwi_draw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAW  = 2'd2
  } draw_state_t;

  // Field positions inside the tile code word
  localparam int HFLIP    = 15;
  localparam int VFLIP    = 14;
  localparam int TILE_MSB = 12;

  // Palette slice inside the attribute word
  localparam int PAL_MSB = 15;
  localparam int PAL_LSB = 11;

  // Pixel value that leaves the line buffer untouched
  localparam logic [3:0] TRANSPARENT = 4'd0;

  // Gather pixel p (0 = leftmost) from a word holding four 8-bit planes,
  // plane 3 in the top byte. Pixel p lives at bit 7-p of each plane byte.
  function automatic logic [3:0] plane_pixel(input logic [31:0] word,
                                             input logic [2:0]  p);
    logic [2:0] bit_idx;
    bit_idx = ~p;  // 7 - p for a 3-bit index
    plane_pixel = {word[{2'd3, bit_idx}], word[{2'd2, bit_idx}],
                   word[{2'd1, bit_idx}], word[{2'd0, bit_idx}]};
  endfunction

endpackage

// File: rtl/jtkiwi_tiledraw_unpack.sv
// Plane de-interleaver: holds the fetched ROM word(s) and produces the
// 4-bit pixel for the current pixel counter and horizontal flip.
// With JTKIWI_TILEDRAW_PREFETCH_EN defined a second word register holds
// the half-1 data so it can be fetched while half 0 is being drawn.
module jtkiwi_tiledraw_unpack
  import jtkiwi_draw_pkg::*;
(
  input  logic        clk,
  input  logic        load0,
`ifdef JTKIWI_TILEDRAW_PREFETCH_EN
  input  logic        load1,
  input  logic        half,
`endif
  input  logic [31:0] rom_data,
  input  logic [2:0]  pix,
  input  logic        hflip,
  output logic [3:0]  pixel
);

  logic [31:0] word0;
  logic [2:0]  pix_idx;

  assign pix_idx = hflip ? ~pix : pix;

  // Capture the word for the half being drawn (or half 0 in prefetch builds)
  // NOTE: no reset on the word registers; each is reloaded before DRAW reads
  // it and the line buffer outputs are gated to zero outside DRAW.
  always_ff @(posedge clk) begin
    if (load0) word0 <= rom_data;
  end

`ifdef JTKIWI_TILEDRAW_PREFETCH_EN
  logic [31:0] word1;

  // Capture the half-1 word fetched during the half-0 pixels
  always_ff @(posedge clk) begin
    if (load1) word1 <= rom_data;
  end

  assign pixel = plane_pixel(half ? word1 : word0, pix_idx);
`else
  assign pixel = plane_pixel(word0, pix_idx);
`endif

endmodule

// File: rtl/jtkiwi_tiledraw.sv
// Tile row renderer: accepts one draw command, fetches the 16-pixel row as
// two 32-bit ROM words and writes the opaque pixels to the line buffer,
// one per clock. Define JTKIWI_TILEDRAW_PREFETCH_EN to overlap the half-1
// ROM fetch with the half-0 pixel writes.
module jtkiwi_tiledraw
  import jtkiwi_draw_pkg::*;
#(
  parameter int HALF_CNT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        draw,
  output logic        busy,
  input  logic [15:0] code,
  input  logic [15:0] attr,
  input  logic [8:0]  xpos,
  input  logic [3:0]  ysub,
  output logic [17:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic [8:0]  buf_addr,
  output logic        buf_we,
  output logic [8:0]  buf_din
);

  localparam logic LAST_HALF = 1'(HALF_CNT - 1);

  draw_state_t       state, state_nx;
  logic [TILE_MSB:0] tile;
  logic              hflip, vflip;
  logic [4:0]        pal;
  logic [8:0]        xpos_r;
  logic [3:0]        ysub_r;
  logic              half;
  logic [2:0]        pix;
  logic              req, req_half, req_first;
  logic              got;
  logic              accept;
  logic              half_end;
  logic              load0;
  logic [3:0]        pixel;
  logic              unused_bits;
`ifdef JTKIWI_TILEDRAW_PREFETCH_EN
  logic              have1;
  logic              load1;
`endif

  assign unused_bits = ^{code[13], attr[PAL_LSB-1:0]};

  // Data is only trusted once the address has been stable for a cycle
  assign got      = req & ~req_first & rom_ok;
  assign accept   = (state == IDLE) & draw;
  assign half_end = (state == DRAW) & (pix == 3'd7) & (half != LAST_HALF);

  assign rom_cs   = req;
  assign rom_addr = req ? {tile, ysub_r ^ {4{vflip}}, req_half ^ hflip} : '0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and line buffer outputs
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_nx = state;
    busy     = 1'b0;
    buf_we   = 1'b0;
    buf_addr = '0;
    buf_din  = '0;
    case (state)
      IDLE: begin
        if (draw) state_nx = FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (got) state_nx = DRAW;
      end
      DRAW: begin
        busy     = 1'b1;
        buf_addr = xpos_r + {5'd0, half, pix};
        buf_din  = {pal, pixel};
        buf_we   = (pixel != TRANSPARENT);
        if (pix == 3'd7) begin
          if (half == LAST_HALF)  state_nx = IDLE;
`ifdef JTKIWI_TILEDRAW_PREFETCH_EN
          else if (have1 || got)  state_nx = DRAW;
`endif
          else                    state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Latch the command fields when a draw is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      tile   <= '0;
      hflip  <= 1'b0;
      vflip  <= 1'b0;
      pal    <= '0;
      xpos_r <= '0;
      ysub_r <= '0;
    end else if (accept) begin
      tile   <= code[TILE_MSB:0];
      hflip  <= code[HFLIP];
      vflip  <= code[VFLIP];
      pal    <= attr[PAL_MSB:PAL_LSB];
      xpos_r <= xpos;
      ysub_r <= ysub;
    end
  end

  // Pixel counter and current half
  always_ff @(posedge clk) begin
    if (rst) begin
      pix  <= '0;
      half <= 1'b0;
    end else begin
      if (state == DRAW) pix <= pix + 3'd1;
      else               pix <= '0;
      if (accept)        half <= 1'b0;
      else if (half_end) half <= 1'b1;
    end
  end

  // ROM request sequencing; req_first marks the cycle after an address change
  always_ff @(posedge clk) begin
    if (rst) begin
      req       <= 1'b0;
      req_half  <= 1'b0;
      req_first <= 1'b0;
`ifdef JTKIWI_TILEDRAW_PREFETCH_EN
      have1     <= 1'b0;
`endif
    end else begin
      req_first <= 1'b0;
      if (accept) begin
        req       <= 1'b1;
        req_half  <= 1'b0;
        req_first <= 1'b1;
`ifdef JTKIWI_TILEDRAW_PREFETCH_EN
        have1     <= 1'b0;
      end else if (got && !req_half) begin
        req_half  <= 1'b1;
        req_first <= 1'b1;
      end else if (got) begin
        req   <= 1'b0;
        have1 <= 1'b1;
      end
`else
      end else if (got) begin
        req <= 1'b0;
      end else if (half_end) begin
        req       <= 1'b1;
        req_half  <= 1'b1;
        req_first <= 1'b1;
      end
`endif
    end
  end

`ifdef JTKIWI_TILEDRAW_PREFETCH_EN
  assign load0 = got & ~req_half;
  assign load1 = got &  req_half;
`else
  assign load0 = got;
`endif

  jtkiwi_tiledraw_unpack u_unpack (
    .clk      (clk),
    .load0    (load0),
`ifdef JTKIWI_TILEDRAW_PREFETCH_EN
    .load1    (load1),
    .half     (half),
`endif
    .rom_data (rom_data),
    .pix      (pix),
    .hflip    (hflip),
    .pixel    (pixel)
  );

endmodule

// File: tb/tb_jtkiwi_tiledraw.sv
// Directed bench for jtkiwi_tiledraw. Honours JTKIWI_TILEDRAW_PREFETCH_EN
// for the timing expectations; pixel data expectations are shared.
module tb_jtkiwi_tiledraw;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        draw = 1'b0;
  logic [15:0] code = '0;
  logic [15:0] attr = '0;
  logic [8:0]  xpos = '0;
  logic [3:0]  ysub = '0;
  logic        busy, rom_cs, rom_ok, buf_we;
  logic [17:0] rom_addr;
  logic [31:0] rom_data;
  logic [8:0]  buf_addr, buf_din;

  int total = 0;
  int bad   = 0;

`ifdef JTKIWI_TILEDRAW_PREFETCH_EN
  localparam int BUSY_FAST  = 18;
  localparam int BUSY_STALL = 32;
  localparam int GAP        = 1;
`else
  localparam int BUSY_FAST  = 20;
  localparam int BUSY_STALL = 40;
  localparam int GAP        = 3;
`endif

  typedef struct {
    logic [8:0] addr;
    logic [8:0] din;
    int         cyc;
  } wr_t;

  wr_t         wr_q[$];
  logic [17:0] fetch_q[$];
  int          busy_n;
  int          cs_n;

  jtkiwi_tiledraw #(.HALF_CNT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .draw     (draw),
    .busy     (busy),
    .code     (code),
    .attr     (attr),
    .xpos     (xpos),
    .ysub     (ysub),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_ok   (rom_ok),
    .rom_data (rom_data),
    .buf_addr (buf_addr),
    .buf_we   (buf_we),
    .buf_din  (buf_din)
  );

  always #5 clk = ~clk;

  // ROM model: registered data, rom_ok after stall_len stable cycles
  int          stall_len = 0;
  int          wait_cnt  = 0;
  logic [17:0] last_addr = '0;

  function automatic logic [31:0] rom_model(input logic [17:0] a);
    if (a[17:5] == 13'h100) return 32'hFFFF_FFFF;
    case (a)
      18'h000A6, 18'h000B8: return 32'h8000_0000;
      18'h000A7, 18'h000B9: return 32'h0000_0001;
      default:              return 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    rom_data <= rom_model(rom_addr);
    if (!rom_cs || rom_addr != last_addr) wait_cnt <= 0;
    else                                  wait_cnt <= wait_cnt + 1;
    last_addr <= rom_addr;
  end

  assign rom_ok = rom_cs && (wait_cnt >= stall_len);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wa(input int i);
    return (i < wr_q.size()) ? 32'(wr_q[i].addr) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] wd(input int i);
    return (i < wr_q.size()) ? 32'(wr_q[i].din) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] wc(input int i);
    return (i < wr_q.size()) ? 32'(wr_q[i].cyc) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] fa(input int i);
    return (i < fetch_q.size()) ? 32'(fetch_q[i]) : 32'hDEAD;
  endfunction

  // Issue one command and record everything until busy drops.
  // cyc 0 is the first cycle after the strobe edge.
  task automatic run_cmd(input logic [15:0] c, input logic [15:0] a,
                         input logic [8:0] x, input logic [3:0] y,
                         input bit spam, input int late_cyc);
    int cyc;
    wr_q.delete();
    fetch_q.delete();
    busy_n = 0;
    cs_n   = 0;
    @(negedge clk);
    code = c; attr = a; xpos = x; ysub = y; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    cyc  = 0;
    while (busy && cyc < 200) begin
      busy_n++;
      if (rom_cs) begin
        cs_n++;
        if (fetch_q.size() == 0 || fetch_q[fetch_q.size()-1] != rom_addr)
          fetch_q.push_back(rom_addr);
      end
      if (buf_we) wr_q.push_back('{buf_addr, buf_din, cyc});
      draw = 1'b0;
      if (spam && cyc >= 3 && cyc <= 5) begin
        code = 16'h0100;
        draw = 1'b1;
      end
      if (cyc == late_cyc) draw = 1'b1;
      cyc++;
      @(negedge clk);
    end
    draw = 1'b0;
    code = c;
    check("no_timeout", 32'(cyc < 200), 1);
    repeat (3) begin
      check("idle_busy", busy, 0);
      check("idle_we", buf_we, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int stray;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cs", rom_cs, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_we", buf_we, 0);
    check("rst_buf_addr", buf_addr, 0);
    check("rst_buf_din", buf_din, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic draw, with a strobe in the last busy cycle that must be dropped
    run_cmd(16'h0005, 16'h1800, 9'h010, 4'd3, 1'b0, BUSY_FAST - 1);
    check("basic_busy", busy_n, BUSY_FAST);
    check("basic_cs_cycles", cs_n, 4);
    check("basic_fetch_n", fetch_q.size(), 2);
    check("basic_fetch0", fa(0), 18'h000A6);
    check("basic_fetch1", fa(1), 18'h000A7);
    check("basic_wr_n", wr_q.size(), 2);
    check("basic_w0_addr", wa(0), 9'h010);
    check("basic_w0_din", wd(0), 9'h038);
    check("basic_w0_cyc", wc(0), 2);
    check("basic_w1_addr", wa(1), 9'h01F);
    check("basic_w1_din", wd(1), 9'h031);
    check("basic_w1_cyc", wc(1), BUSY_FAST - 1);

    // hflip + vflip
    run_cmd(16'hC005, 16'h1800, 9'h010, 4'd3, 1'b0, -1);
    check("flip_busy", busy_n, BUSY_FAST);
    check("flip_fetch0", fa(0), 18'h000B9);
    check("flip_fetch1", fa(1), 18'h000B8);
    check("flip_wr_n", wr_q.size(), 2);
    check("flip_w0_addr", wa(0), 9'h010);
    check("flip_w0_din", wd(0), 9'h031);
    check("flip_w1_addr", wa(1), 9'h01F);
    check("flip_w1_din", wd(1), 9'h038);

    // Wrap-around with all pixels opaque
    run_cmd(16'h0100, 16'h0000, 9'h1FC, 4'd0, 1'b0, -1);
    check("wrap_busy", busy_n, BUSY_FAST);
    check("wrap_wr_n", wr_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wrap_addr%0d", i), wa(i), (32'h1FC + i) & 32'h1FF);
      check($sformatf("wrap_din%0d", i), wd(i), 9'h00F);
    end
    check("wrap_gap_7_8", wc(8) - wc(7), GAP);
    check("wrap_span", wc(15) - wc(0), 14 + GAP);

    // ROM stall with strobes while busy
    stall_len = 10;
    run_cmd(16'h0005, 16'h1800, 9'h010, 4'd3, 1'b1, -1);
    stall_len = 0;
    check("stall_busy", busy_n, BUSY_STALL);
    check("stall_cs_cycles", cs_n, 24);
    check("stall_wr_n", wr_q.size(), 2);
    check("stall_w0_cyc", wc(0), 12);
    check("stall_w0_din", wd(0), 9'h038);
    check("stall_w1_din", wd(1), 9'h031);
    check("stall_w1_cyc", wc(1), BUSY_STALL - 1);

    // Reset in the middle of half-0 pixels
    @(negedge clk);
    code = 16'h0005; attr = 16'h1800; xpos = 9'h010; ysub = 4'd3; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_pix4_addr", buf_addr, 9'h014);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cs", rom_cs, 0);
    check("mid_rst_we", buf_we, 0);
    rst = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (buf_we || busy || rom_cs) stray++;
    end
    check("mid_no_activity", stray, 0);

    run_cmd(16'h0005, 16'h1800, 9'h010, 4'd3, 1'b0, -1);
    check("after_rst_busy", busy_n, BUSY_FAST);
    check("after_rst_wr_n", wr_q.size(), 2);
    check("after_rst_w0_din", wd(0), 9'h038);
    check("after_rst_w1_addr", wa(1), 9'h01F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
